// File: rtl/msrv32_branch_predict_unit.sv
// rtl/msrv32_branch_predict_unit.sv - RV32I branch resolver with 2-bit BHT predictor; optional gshare via MSRV32_GSHARE_EN
module msrv32_branch_predict_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64
) (
   input  logic            ms_riscv32_mp_clk_in,
   input  logic            ms_riscv32_mp_rst_n_in,
   input  logic            pred_valid_in,
   input  logic [XLEN-1:0] pred_pc_in,
   output logic            pred_valid_out,
   output logic            pred_taken_out,
   input  logic            res_valid_in,
   input  logic [XLEN-1:0] res_pc_in,
   input  logic [XLEN-1:0] rs1_in,
   input  logic [XLEN-1:0] rs2_in,
   input  logic [4:0]      opcode_6_to_2_in,
   input  logic [2:0]      funct3_in,
   input  logic            res_pred_taken_in,
   output logic            res_valid_out,
   output logic            branch_taken_out,
   output logic            mispredict_out,
   output logic [31:0]     mispredict_count_out
);

   localparam int         IDX = $clog2(BHT_DEPTH);
   localparam logic [1:0] WNT = 2'b01;

   logic [1:0]     bht_q [BHT_DEPTH];
   logic [1:0]     bht_d [BHT_DEPTH];
   logic [IDX-1:0] lookup_idx;
   logic [IDX-1:0] update_idx;
   logic           is_cond;
   logic           actual_taken;
   logic           eq, lt_s, lt_u;
   logic           pred_valid_q, pred_valid_d;
   logic           pred_taken_q, pred_taken_d;
   logic           res_valid_q, res_valid_d;
   logic           branch_taken_q, branch_taken_d;
   logic           mispredict_q, mispredict_d;
   logic [31:0]    count_q, count_d;
   logic           unused_pc_bits;

   // PC bits outside the word index never reach the table.
   assign unused_pc_bits = ^{pred_pc_in[XLEN-1:IDX+2], pred_pc_in[1:0],
                             res_pc_in[XLEN-1:IDX+2], res_pc_in[1:0]};

`ifdef MSRV32_GSHARE_EN
   logic [IDX-1:0] ghr_q, ghr_d;

   // Both ports hash with the history as it stands before this cycle's shift.
   assign lookup_idx = pred_pc_in[IDX+1:2] ^ ghr_q;
   assign update_idx = res_pc_in[IDX+1:2] ^ ghr_q;

   // Shift in the resolved direction of every legal conditional branch.
   always_comb begin
      ghr_d = ghr_q;
      if (res_valid_in && is_cond) ghr_d = (ghr_q << 1) | IDX'(actual_taken);
   end

   // History register.
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) ghr_q <= '0;
      else                         ghr_q <= ghr_d;
   end
`else
   assign lookup_idx = pred_pc_in[IDX+1:2];
   assign update_idx = res_pc_in[IDX+1:2];
`endif

   assign eq   = (rs1_in == rs2_in);
   assign lt_s = ($signed(rs1_in) < $signed(rs2_in));
   assign lt_u = (rs1_in < rs2_in);

   // Decode the resolving instruction into direction and table-update eligibility.
   always_comb begin
      is_cond      = 1'b0;
      actual_taken = 1'b0;
      case (opcode_6_to_2_in)
         5'b11011, 5'b11001: actual_taken = 1'b1;
         5'b11000: begin
            is_cond = 1'b1;
            case (funct3_in)
               3'b000:  actual_taken = eq;
               3'b001:  actual_taken = ~eq;
               3'b100:  actual_taken = lt_s;
               3'b101:  actual_taken = ~lt_s;
               3'b110:  actual_taken = lt_u;
               3'b111:  actual_taken = ~lt_u;
               default: is_cond = 1'b0;
            endcase
         end
         default: ;
      endcase
   end

   // Saturating counter update; the lookup reads bht_q so it sees the old value.
   always_comb begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_d[i] = bht_q[i];
      if (res_valid_in && is_cond) begin
         if (actual_taken) begin
            if (bht_q[update_idx] != 2'b11) bht_d[update_idx] = bht_q[update_idx] + 2'd1;
         end else begin
            if (bht_q[update_idx] != 2'b00) bht_d[update_idx] = bht_q[update_idx] - 2'd1;
         end
      end
   end

   // Next values for the registered lookup/resolve results and the mispredict counter.
   always_comb begin
      pred_valid_d   = pred_valid_in;
      pred_taken_d   = pred_valid_in & bht_q[lookup_idx][1];
      res_valid_d    = res_valid_in;
      branch_taken_d = res_valid_in & actual_taken;
      mispredict_d   = res_valid_in & (actual_taken ^ res_pred_taken_in);
      count_d        = count_q;
      if (mispredict_d && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
   end

   // State registers; reset drops in-flight results and reinitialises the table to WNT.
   always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= WNT;
         pred_valid_q   <= 1'b0;
         pred_taken_q   <= 1'b0;
         res_valid_q    <= 1'b0;
         branch_taken_q <= 1'b0;
         mispredict_q   <= 1'b0;
         count_q        <= '0;
      end else begin
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= bht_d[i];
         pred_valid_q   <= pred_valid_d;
         pred_taken_q   <= pred_taken_d;
         res_valid_q    <= res_valid_d;
         branch_taken_q <= branch_taken_d;
         mispredict_q   <= mispredict_d;
         count_q        <= count_d;
      end
   end

   assign pred_valid_out       = pred_valid_q;
   assign pred_taken_out       = pred_taken_q;
   assign res_valid_out        = res_valid_q;
   assign branch_taken_out     = branch_taken_q;
   assign mispredict_out       = mispredict_q;
   assign mispredict_count_out = count_q;

endmodule
